// File: rtl/operand_loader_if.sv
// Operand stream, datapath read port and controller handshake for operand_loader.
interface operand_loader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              start;
  logic              busy;
  logic [ADDR_W:0]   fill_cnt;
  logic              zero_err;

  // Driven by upstream, datapath and controller.
  modport master (
    output in_valid, in_data, rd_addr, done,
    input  in_ready, rd_data, start, busy, fill_cnt, zero_err
  );

  // Driven by the loader.
  modport slave (
    input  in_valid, in_data, rd_addr, done,
    output in_ready, rd_data, start, busy, fill_cnt, zero_err
  );
endinterface

// File: rtl/operand_loader.sv
// Buffers one batch of DEPTH operand words, launches the controller, and waits for done.
// Optional zero-operand substitution and sticky flag: define OPERAND_LOADER_ZERO_CHECK_EN.
module operand_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  operand_loader_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  fill_cnt;
  logic              in_ready;
  logic              start;
  logic              busy;
  logic              zero_err;
  logic              accept_c;
  logic              release_c;
  logic              zero_word_c;
  logic [DATA_W-1:0] store_data_c;
  logic [DATA_W-1:0] mem [DEPTH];

  assign accept_c    = bus.in_valid & in_ready;
  assign zero_word_c = (bus.in_data == '0);

`ifdef OPERAND_LOADER_ZERO_CHECK_EN
  // A zero operand would stall the controller's leading-one search, so store 1.
  assign store_data_c = zero_word_c ? DATA_W'(1) : bus.in_data;
`else
  assign store_data_c = bus.in_data;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    release_c = 1'b0;
    case (state)
      ST_FILL: begin
        if (accept_c && (wr_ptr == LAST_ADDR)) begin
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.done) begin
          state_nxt = ST_FILL;
          release_c = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_FILL;
      end
    endcase
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      zero_err <= 1'b0;
      in_ready <= 1'b1;
      start    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == ST_FILL);
      start    <= (state_nxt == ST_LAUNCH);
      busy     <= (state_nxt != ST_FILL);
      if (release_c) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
        zero_err <= 1'b0;
      end else if (accept_c) begin
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        fill_cnt <= fill_cnt + CNT_W'(1);
`ifdef OPERAND_LOADER_ZERO_CHECK_EN
        if (zero_word_c) begin
          zero_err <= 1'b1;
        end
`endif
      end
    end
  end

  // Register file keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= store_data_c;
    end
  end

  assign bus.rd_data  = mem[bus.rd_addr];
  assign bus.in_ready = in_ready;
  assign bus.start    = start;
  assign bus.busy     = busy;
  assign bus.fill_cnt = fill_cnt;
  assign bus.zero_err = zero_err;
endmodule

// File: tb/tb_operand_loader.sv
// Directed and randomized checks of operand_loader against a batch-level reference model.
module tb_operand_loader;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Reference model: words stored so far in this batch and the expected sticky flag.
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  int                mdl_cnt = 0;
  logic              mdl_zerr = 1'b0;

  operand_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  operand_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] stored_value(input logic [DATA_W-1:0] w);
`ifdef OPERAND_LOADER_ZERO_CHECK_EN
    return (w == '0) ? DATA_W'(1) : w;
`else
    return w;
`endif
  endfunction

  function automatic logic zero_flags(input logic [DATA_W-1:0] w);
`ifdef OPERAND_LOADER_ZERO_CHECK_EN
    return (w == '0);
`else
    return 1'b0 & w[0];
`endif
  endfunction

  task automatic model_clear();
    mdl_cnt  = 0;
    mdl_zerr = 1'b0;
  endtask

  // Present one word after 'gap' idle cycles and hold it until the loader takes it.
  task automatic push(input logic [DATA_W-1:0] w, input int gap, input bit keep_valid);
    bit taken = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int c = 0; c < 50 && !taken; c++) begin
      taken = bus.in_ready;
      tick();
    end
    if (!keep_valid) bus.in_valid = 1'b0;
    if (!taken) begin
      check("push_timeout", 32'd1, 32'd0);
    end else begin
      mdl_mem[mdl_cnt] = stored_value(w);
      mdl_cnt++;
      mdl_zerr = mdl_zerr | zero_flags(w);
      check("fill_cnt", 32'(bus.fill_cnt), 32'(mdl_cnt));
      check("zero_err", 32'(bus.zero_err), 32'(mdl_zerr));
      check("start_at_word", 32'(bus.start), 32'(mdl_cnt == DEPTH));
    end
  endtask

  // Called right after the final handshake: one-cycle start, then contents read back.
  task automatic check_launch();
    check("launch_busy", 32'(bus.busy), 32'd1);
    check("launch_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("start_width", 32'(bus.start), 32'd0);
    check("wait_busy", 32'(bus.busy), 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = ADDR_W'(a);
      #1;
      check("readback", 32'(bus.rd_data), 32'(mdl_mem[a]));
    end
  endtask

  task automatic finish_batch();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    model_clear();
    check("release_ready", 32'(bus.in_ready), 32'd1);
    check("release_busy", 32'(bus.busy), 32'd0);
    check("release_cnt", 32'(bus.fill_cnt), 32'd0);
    check("release_zerr", 32'(bus.zero_err), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_start"}, 32'(bus.start), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_cnt"}, 32'(bus.fill_cnt), 32'd0);
    check({tag, "_zerr"}, 32'(bus.zero_err), 32'd0);
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    return DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_addr  = '0;
    bus.done     = 1'b0;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Back-to-back batch 0x0011..0x0020.
    for (int i = 0; i < DEPTH; i++) push(DATA_W'(16'h0011 + i), 0, (i == DEPTH - 1));
    bus.rd_addr = ADDR_W'(5);
    #1;
    check("addr5", 32'(bus.rd_data), 32'h0016);
    // Hold a word during WAIT; it must stay pending.
    bus.in_data = 16'hABCD;
    check_launch();
    for (int c = 0; c < 20; c++) begin
      tick();
      check("wait_hold_cnt", 32'(bus.fill_cnt), 32'(DEPTH));
      check("wait_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    finish_batch();
    tick();
    mdl_mem[0] = stored_value(16'hABCD);
    mdl_cnt    = 1;
    bus.in_valid = 1'b0;
    check("held_word_cnt", 32'(bus.fill_cnt), 32'd1);
    bus.rd_addr = '0;
    #1;
    check("held_word", 32'(bus.rd_data), 32'hABCD);

    // Every-other-cycle valid with random data completes the batch.
    for (int i = 1; i < DEPTH; i++) push(rnd_word(), 1, 1'b0);
    check_launch();
    finish_batch();

    // done during FILL is ignored.
    for (int i = 0; i < 3; i++) push(rnd_word(), $urandom_range(0, 2), 1'b0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("fill_done_cnt", 32'(bus.fill_cnt), 32'd3);
    check("fill_done_ready", 32'(bus.in_ready), 32'd1);
    check("fill_done_busy", 32'(bus.busy), 32'd0);

    // Reset after 7 words, then a full batch with a zero operand as word 4.
    for (int i = 3; i < 7; i++) push(rnd_word(), 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check_idle("mid_rst");
    for (int i = 0; i < DEPTH; i++) push((i == 4) ? DATA_W'(0) : rnd_word(), $urandom_range(0, 1), 1'b0);
    bus.rd_addr = ADDR_W'(4);
    #1;
`ifdef OPERAND_LOADER_ZERO_CHECK_EN
    check("zero_word", 32'(bus.rd_data), 32'h0001);
    check("zero_flag", 32'(bus.zero_err), 32'd1);
`else
    check("zero_word", 32'(bus.rd_data), 32'h0000);
    check("zero_flag", 32'(bus.zero_err), 32'd0);
`endif
    check_launch();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("zero_flag_wait", 32'(bus.zero_err), 32'(mdl_zerr));
    end
    finish_batch();

    // Reset while the controller owns a batch; rst wins over a simultaneous done.
    for (int i = 0; i < DEPTH; i++) push(rnd_word(), 0, 1'b0);
    check_launch();
    rst = 1'b1;
    bus.done = 1'b1;
    tick();
    rst = 1'b0;
    bus.done = 1'b0;
    model_clear();
    check_idle("wait_rst");
    for (int i = 0; i < DEPTH; i++) push(rnd_word(), $urandom_range(0, 3), 1'b0);
    check_launch();
    finish_batch();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
